// File: rtl/encrypted_block_loader.sv
// Read controller for the encrypted-data FIFO: pops bytes into a 128-bit block and hands it to AES.
// Define AES_PAD_TIMEOUT_EN to zero-pad and release a partial block after TIMEOUT_CYC idle cycles.
module encrypted_block_loader #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BLK_BYTES = 16
`ifdef AES_PAD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fifo_empty,
    input  logic [DATA_W-1:0]             fifo_rdata,
    output logic                          fifo_r_enable,
    output logic [DATA_W*BLK_BYTES-1:0]   blk_data,
    output logic [4:0]                    blk_nbytes,
    output logic                          blk_valid,
    input  logic                          blk_ready,
    output logic                          busy
);

    localparam int unsigned BlkW    = DATA_W * BLK_BYTES;
    localparam logic [4:0]  LastCnt = 5'(BLK_BYTES - 1);
    localparam logic [4:0]  FullCnt = 5'(BLK_BYTES);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [BlkW-1:0]   blk_data_q, blk_data_d;
    logic [4:0]        blk_nbytes_q, blk_nbytes_d;
    logic              blk_valid_q;
    logic              busy_q;

`ifdef AES_PAD_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

    logic [15:0] idle_q, idle_d;
    logic [7:0]  pad_shift;

    // Bit distance that moves the cnt real bytes up to the MSB end of the block.
    assign pad_shift = {FullCnt - cnt_q, 3'b000};
`endif

    assign fifo_r_enable = (state_q == StFill) & ~fifo_empty & ~rst;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        blk_data_d   = blk_data_q;
        blk_nbytes_d = blk_nbytes_q;
`ifdef AES_PAD_TIMEOUT_EN
        idle_d       = idle_q;
`endif
        case (state_q)
            StFill: begin
                if (fifo_r_enable) begin
                    blk_data_d = {blk_data_q[BlkW-DATA_W-1:0], fifo_rdata};
                    cnt_d      = cnt_q + 5'd1;
`ifdef AES_PAD_TIMEOUT_EN
                    idle_d     = '0;
`endif
                    if (cnt_q == LastCnt) begin
                        state_d      = StHold;
                        blk_nbytes_d = FullCnt;
                    end
`ifdef AES_PAD_TIMEOUT_EN
                end else if (fifo_empty && cnt_q != 5'd0) begin
                    if (idle_q == TimeoutLast) begin
                        blk_data_d   = blk_data_q << pad_shift;
                        blk_nbytes_d = cnt_q;
                        state_d      = StHold;
                        idle_d       = '0;
                    end else begin
                        idle_d = idle_q + 16'd1;
                    end
`endif
                end
            end
            StHold: begin
                if (blk_ready) begin
                    cnt_d   = 5'd0;
                    state_d = StFill;
`ifdef AES_PAD_TIMEOUT_EN
                    idle_d  = '0;
`endif
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFill;
            cnt_q        <= 5'd0;
            blk_data_q   <= '0;
            blk_nbytes_q <= 5'd0;
            blk_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef AES_PAD_TIMEOUT_EN
            idle_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            blk_data_q   <= blk_data_d;
            blk_nbytes_q <= blk_nbytes_d;
            blk_valid_q  <= (state_d == StHold);
            busy_q       <= (cnt_d != 5'd0) | (state_d == StHold);
`ifdef AES_PAD_TIMEOUT_EN
            idle_q       <= idle_d;
`endif
        end
    end

    assign blk_data   = blk_data_q;
    assign blk_nbytes = blk_nbytes_q;
    assign blk_valid  = blk_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_encrypted_block_loader.sv
// Directed bench for encrypted_block_loader: a byte-queue FIFO model drives the loader and
// each block is compared with hand-computed values.
module tb_encrypted_block_loader;

    logic         clk;
    logic         rst;
    logic         fifo_empty;
    logic [7:0]   fifo_rdata;
    logic         fifo_r_enable;
    logic [127:0] blk_data;
    logic [4:0]   blk_nbytes;
    logic         blk_valid;
    logic         blk_ready;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    int bad_pops = 0;
    logic [7:0] q[$];
    logic avail;
    logic last_pop;

    encrypted_block_loader #(
        .DATA_W    (8),
        .BLK_BYTES (16)
`ifdef AES_PAD_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (8)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_rdata    (fifo_rdata),
        .fifo_r_enable (fifo_r_enable),
        .blk_data      (blk_data),
        .blk_nbytes    (blk_nbytes),
        .blk_valid     (blk_valid),
        .blk_ready     (blk_ready),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_range(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) q.push_back(first + 8'(i));
    endtask

    // Called at a falling edge; drives the FIFO, runs one rising edge, returns at the next fall.
    task automatic cycle();
        fifo_empty = !(avail && q.size() != 0);
        fifo_rdata = (q.size() != 0) ? q[0] : 8'h00;
        #1;
        last_pop = fifo_r_enable;
        if (fifo_r_enable && fifo_empty) bad_pops++;
        @(posedge clk);
        if (last_pop && q.size() != 0) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic run_until_valid(input string tag, input int max_cyc, output int cyc);
        cyc = 0;
        while (!blk_valid && cyc < max_cyc) begin
            cycle();
            cyc++;
        end
        check(tag, 128'(blk_valid), 128'd1);
    endtask

    initial begin
        int cyc;
        logic [127:0] held;

        rst        = 1'b1;
        avail      = 1'b1;
        blk_ready  = 1'b0;
        fifo_empty = 1'b1;
        fifo_rdata = 8'h00;
        push_range(8'h00, 16);
        @(negedge clk);

        // Reset with a non-empty FIFO: no pops, all outputs zero.
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_no_pop", 128'(last_pop), 128'd0);
        end
        check("rst_data", blk_data, 128'd0);
        check("rst_nbytes", 128'(blk_nbytes), 128'd0);
        check("rst_valid", 128'(blk_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);

        // Back-to-back block with ready held high.
        rst       = 1'b0;
        blk_ready = 1'b1;
        run_until_valid("b2b_valid", 40, cyc);
        check("b2b_cycles", 128'(cyc), 128'd16);
        check("b2b_data", blk_data, 128'h000102030405060708090A0B0C0D0E0F);
        check("b2b_nbytes", 128'(blk_nbytes), 128'd16);
        check("b2b_busy", 128'(busy), 128'd1);
        cycle();
        check("b2b_valid_1cyc", 128'(blk_valid), 128'd0);
        check("b2b_busy_idle", 128'(busy), 128'd0);

        // Backpressure: block held, no pops while the FIFO still has data.
        blk_ready = 1'b0;
        push_range(8'h20, 16);
        push_range(8'h30, 16);
        run_until_valid("hold_valid", 40, cyc);
        held = blk_data;
        check("hold_data", held, 128'h202122232425262728292A2B2C2D2E2F);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("hold_no_pop", 128'(last_pop), 128'd0);
            check("hold_stable", blk_data, 128'h202122232425262728292A2B2C2D2E2F);
        end
        blk_ready = 1'b1;
        cycle();
        check("hs_no_pop", 128'(last_pop), 128'd0);
        check("hs_valid_low", 128'(blk_valid), 128'd0);
        cycle();
        check("hs_pop_resume", 128'(last_pop), 128'd1);
        run_until_valid("hold2_valid", 40, cyc);
        check("hold2_cycles", 128'(cyc), 128'd15);
        check("hold2_data", blk_data, 128'h303132333435363738393A3B3C3D3E3F);
        cycle();

        // Random empty gaps between bytes.
        push_range(8'hF0, 16);
        for (int i = 0; i < 16; i++) begin
            avail = 1'b0;
            repeat ($urandom_range(1, 5)) cycle();
            if (i == 8) check("gap_busy", 128'(busy), 128'd1);
            avail = 1'b1;
            cycle();
        end
        check("gap_valid", 128'(blk_valid), 128'd1);
        check("gap_data", blk_data, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        check("gap_no_empty_pop", 128'(bad_pops), 128'd0);
        cycle();

        // Reset mid-fill discards the partial block.
        push_range(8'h40, 7);
        repeat (7) cycle();
        check("mid_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        cycle();
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_data", blk_data, 128'd0);
        rst = 1'b0;
        push_range(8'h10, 16);
        run_until_valid("post_rst_valid", 40, cyc);
        check("post_rst_data", blk_data, 128'h101112131415161718191A1B1C1D1E1F);
        cycle();

`ifdef AES_PAD_TIMEOUT_EN
        // Partial block padded after eight idle cycles.
        push_range(8'hAA, 0);
        q.push_back(8'hAA); q.push_back(8'hBB); q.push_back(8'hCC);
        q.push_back(8'hDD); q.push_back(8'hEE);
        blk_ready = 1'b0;
        repeat (5) cycle();
        repeat (7) cycle();
        check("pad_early", 128'(blk_valid), 128'd0);
        cycle();
        check("pad_valid", 128'(blk_valid), 128'd1);
        check("pad_data", blk_data, 128'hAABBCCDDEE0000000000000000000000);
        check("pad_nbytes", 128'(blk_nbytes), 128'd5);
        blk_ready = 1'b1;
        cycle();

        // A pop on the eighth idle cycle wins over the timeout.
        push_range(8'h01, 5);
        repeat (5) cycle();
        repeat (7) cycle();
        q.push_back(8'h06);
        cycle();
        check("race_pop", 128'(last_pop), 128'd1);
        check("race_no_pad", 128'(blk_valid), 128'd0);
        repeat (7) cycle();
        check("race_early", 128'(blk_valid), 128'd0);
        cycle();
        check("race_valid", 128'(blk_valid), 128'd1);
        check("race_data", blk_data, 128'h01020304050600000000000000000000);
        check("race_nbytes", 128'(blk_nbytes), 128'd6);
        cycle();
`else
        // Without padding a partial block waits indefinitely.
        push_range(8'hAA, 5);
        repeat (300) cycle();
        check("nopad_valid", 128'(blk_valid), 128'd0);
        check("nopad_busy", 128'(busy), 128'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
